// File: rtl/uart_pkg.sv
// Shared UART constants and serialiser state encodings (also used by the loader's receiver).
// Optional parity build: define UART_TX_PARITY_EN (8E1 framing); undefined gives 8N1.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 5208;
  localparam int unsigned UART_FIFO_DEPTH   = 8;
  localparam int unsigned UART_DATA_BITS    = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;
`else
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Byte-push and status bundle between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;

  modport master (output wr_en, output wr_data,
                  input  full, input empty, input busy, input tx);

  modport slave  (input  wr_en, input wr_data,
                  output full, output empty, output busy, output tx);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data and registered full/empty flags.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  // Acceptance uses the flags as registered this cycle, regardless of a same-cycle pop.
  assign w_wr        = wr_en & ~r_full;
  assign w_rd        = rd_en & ~r_empty;
  assign w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO-fed serialiser driving LSB-first frames from a flop on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_tx_if.slave  bus
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);

  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_pop;
  logic              w_baud_end;
  logic [7:0]        w_rd_data;
  logic              w_full;
  logic              w_empty;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
  logic              w_par_nxt;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Next-state and next-line logic; the shift register moves right so bit 0 is always next out.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        w_pop    = ~w_empty;
      end

      ST_START: begin
        w_baud_nxt = r_baud + BAUD_W'(1);
        if (w_baud_end) begin
          w_state_nxt = ST_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end
      end

      ST_DATA: begin
        w_baud_nxt = r_baud + BAUD_W'(1);
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_baud_nxt = r_baud + BAUD_W'(1);
        if (w_baud_end) begin
          w_state_nxt = ST_STOP;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        w_baud_nxt = r_baud + BAUD_W'(1);
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (w_empty) w_state_nxt = ST_IDLE;
          else         w_pop       = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A pop from IDLE or the last stop cycle loads the next byte and starts its start bit.
    if (w_pop) begin
      w_state_nxt = ST_START;
      w_shift_nxt = w_rd_data;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
      w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = ^w_rd_data;
`endif
    end
  end

  assign bus.tx    = r_tx;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.busy  = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: the sending end of the same 8N1 serial link that the program loader receives on. The CPU side, or a debug or dump engine, pushes bytes into a small FIFO. The block serialises them LSB-first on `tx` at a fixed bit period, so results and state can be streamed back to the host. It sits beside the loader in the top level and drives the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2.
- `FIFO_DEPTH`, 8: byte entries in the TX FIFO; must be a power of two, ≥ 2.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: push `wr_data` into the FIFO this cycle.
- `wr_data` in 8: byte to transmit.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes (registered).
- `empty` out 1: FIFO holds 0 bytes (registered).
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `tx` out 1: serial line, idle high (registered).

## Operation
- **Reset (async, `reset_n`=0):**
  - `tx`=1, `busy`=0, `full`=0, `empty`=1.
  - FIFO is flushed and pointers are zeroed.
  - FSM goes to IDLE and the bit/baud counters clear.
  - Reset asserted mid-frame truncates the frame. `tx` goes high immediately and no partial byte resumes.
- **Write:**
  - A byte is accepted on an edge with `wr_en`=1 and `full`=0.
  - A write while `full`=1 is dropped silently; FIFO contents are unchanged.
  - The `full` sampled in the same cycle decides acceptance, even if a pop occurs that cycle.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP.
  - IDLE: `tx`=1. If `empty`=0, pop the head byte into the shift register, go to START, drive `tx`=0.
  - START: hold for `CLKS_PER_BIT` cycles, then go to DATA and drive bit 0.
  - DATA: 8 bits LSB-first, each held `CLKS_PER_BIT` cycles. After bit 7, go to PARITY if enabled, else STOP with `tx`=1.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. On the final cycle:
    - if `empty`=0, pop and go directly to START (no idle gap between queued frames);
    - else go to IDLE.
- **Counters:**
  - Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. Width is `$clog2(CLKS_PER_BIT)`.
  - Bit index counts 0..7.
- **FIFO:**
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth.
  - Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
  - Simultaneous accepted write and pop leave the count unchanged. At count 1 this keeps `empty`=0.
- `busy` = (state ≠ IDLE) | ~`empty`.

## Timing
- Write-to-line latency with FIFO empty and FSM in IDLE:
  - write captured at edge E0; `empty` falls after E0;
  - FSM pops at E1, and `tx` falls after E1.
- Frame length: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back frames: next start bit begins exactly `CLKS_PER_BIT` cycles after the stop bit began.
- `full`/`empty` update on the edge after the write or pop that changes them.
- `tx` is glitch-free: driven straight from a flop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a PARITY state is inserted after bit 7, driving even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles;
  - frame is 11 bits (8E1).
- Undefined: no PARITY state, no parity logic; frame is 8N1.
- The receiver must be built with the matching setting.

## Structure
- Shared package `uart_pkg`: FSM state encodings, default `CLKS_PER_BIT`, frame-length constants.
  - The loader's receiver uses the same constants.
- One sub-module, `uart_tx_fifo`: synchronous single-clock FIFO with `wr_en`/`wr_data`/`rd_en`/`rd_data`/`full`/`empty`.
  - Registered flags, async active-low reset.
- Serialiser FSM, baud counter and shift register live in `uart_tx`.

## Test plan
- **Reset values:** `reset_n`=0 → `tx`=1, `busy`=0, `full`=0, `empty`=1.
- **Single byte:** `CLKS_PER_BIT`=4, write 0xA5.
  - `tx` falls 1 cycle after the write edge.
  - Line pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `busy` drops after the 40th cycle.
- **Fill FIFO:** 8 consecutive writes 0x00..0x07, then a 9th write 0xFF while `full`=1.
  - 0xFF is dropped.
  - Exactly 8 frames are sent in order, with no idle gap between stop and start bits.
- **Write during pop:** with exactly 1 byte queued, a write coincides with the FSM pop.
  - Count stays 1 and `empty` stays 0.
  - Both bytes are transmitted.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 of 0x3C.
  - `tx`=1 immediately.
  - After release, the line stays idle and `empty`=1.
- **Parity** (`UART_TX_PARITY_EN` defined): write 0x07.
  - Parity bit is 1, stop bit follows.
  - Frame is 44 cycles at `CLKS_PER_BIT`=4.
